// File: rtl/pwl_if.sv
// pwl_if: valid/ready stream bundle carrying pre-activations in and activations out
interface pwl_if #(parameter int WL = 16);
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [WL-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_data;
  modport master (output in_valid, in_mode, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_mode, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/pwl_activation.sv
// pwl_activation: 3-stage piecewise-linear sigmoid/tanh unit; define PWL_ROUND_EN for round-half-up segment shifts
module pwl_activation #(
  parameter int WL = 16,
  parameter int FL = 12
) (
  input logic  clk,
  input logic  rst_n,
  pwl_if.slave bus
);
  localparam int ONE_I = 1 << FL;
  localparam logic [WL-1:0] MAX  = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] ONE  = WL'(ONE_I);
  localparam logic [WL-1:0] C5   = WL'(5 * ONE_I);
  localparam logic [WL-1:0] C238 = WL'(19 * ONE_I / 8);
  localparam logic [WL-1:0] K5   = WL'(27 * ONE_I / 32);
  localparam logic [WL-1:0] K3   = WL'(5 * ONE_I / 8);
  localparam logic [WL-1:0] K2   = WL'(ONE_I / 2);

  logic          v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic          s1_q, s2_q, s1_d, s2_d;
  logic          md1_q, md2_q, md1_d, md2_d;
  logic [WL-1:0] m1_q, p2_q, y_q, m1_d, p2_d, y_d;
  logic          adv;
  logic [WL:0]   xe, ax;
  logic [WL+1:0] a;
  logic [WL-1:0] sh5, sh3, sh2, p, s;

  assign adv          = !v3_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3_q;
  assign bus.out_data = y_q;

  // stage 1: |x| (doubled for tanh), clamped to the largest positive code; sign(t) equals sign(x)
  always_comb begin
    xe    = {bus.in_data[WL-1], bus.in_data};
    ax    = bus.in_data[WL-1] ? -xe : xe;
    a     = bus.in_mode ? {ax, 1'b0} : {1'b0, ax};
    v1_d  = adv ? bus.in_valid : v1_q;
    m1_d  = adv ? ((a > {2'b0, MAX}) ? MAX : a[WL-1:0]) : m1_q;
    s1_d  = adv ? bus.in_data[WL-1] : s1_q;
    md1_d = adv ? bus.in_mode : md1_q;
  end

  // stage 2: positive-half segment lookup on the magnitude
  always_comb begin
`ifdef PWL_ROUND_EN
    sh5 = (m1_q + WL'(16)) >> 5;
    sh3 = (m1_q + WL'(4)) >> 3;
    sh2 = (m1_q + WL'(2)) >> 2;
`else
    sh5 = m1_q >> 5;
    sh3 = m1_q >> 3;
    sh2 = m1_q >> 2;
`endif
    p     = (m1_q >= C5) ? ONE : (m1_q >= C238) ? sh5 + K5 : (m1_q >= ONE) ? sh3 + K3 : sh2 + K2;
    v2_d  = adv ? v1_q : v2_q;
    p2_d  = adv ? p : p2_q;
    s2_d  = adv ? s1_q : s2_q;
    md2_d = adv ? md1_q : md2_q;
  end

  // stage 3: restore sign by symmetry, then map to tanh range when requested
  always_comb begin
    s    = s2_q ? ONE - p2_q : p2_q;
    v3_d = adv ? v2_q : v3_q;
    y_d  = adv ? (md2_q ? (s << 1) - ONE : s) : y_q;
  end

  // pipeline registers; reset drops every in-flight word at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      md1_q <= 1'b0;
      md2_q <= 1'b0;
      m1_q  <= '0;
      p2_q  <= '0;
      y_q   <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      md1_q <= md1_d;
      md2_q <= md2_d;
      m1_q  <= m1_d;
      p2_q  <= p2_d;
      y_q   <= y_d;
    end
  end
endmodule

// File: tb/tb_pwl_activation.sv
// tb_pwl_activation: scoreboard bench for pwl_activation against an arithmetic PLAN model
module tb_pwl_activation;
  localparam int WL  = 16;
  localparam int FL  = 12;
  localparam int ONE = 1 << FL;
  localparam int MAX = (1 << (WL - 1)) - 1;
`ifdef PWL_ROUND_EN
  localparam int X6_EXP = 2050;
`else
  localparam int X6_EXP = 2049;
`endif

  typedef struct {int y; int c;} ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pwl_if #(.WL(WL)) bus ();
  pwl_activation #(.WL(WL), .FL(FL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cur_exp = 0;
  bit chk_lat = 1'b0;
  bit prev_stall = 1'b0;
  logic [WL-1:0] prev_data = '0;
  ent_t exp_q[$];
  ent_t e;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int seg_shift(int m, int k);
`ifdef PWL_ROUND_EN
    return (m + (1 << (k - 1))) / (1 << k);
`else
    return m / (1 << k);
`endif
  endfunction

  function automatic int model(int x, bit md);
    int t, m, p, s;
    t = md ? 2 * x : x;
    if (md && t > MAX) t = MAX;
    if (md && t < -MAX) t = -MAX;
    m = (t < 0) ? -t : t;
    if (m > MAX) m = MAX;
    if (m >= 5 * ONE) p = ONE;
    else if (m * 8 >= 19 * ONE) p = seg_shift(m, 5) + 27 * ONE / 32;
    else if (m >= ONE) p = seg_shift(m, 3) + 5 * ONE / 8;
    else p = seg_shift(m, 2) + ONE / 2;
    s = (t < 0) ? ONE - p : p;
    return md ? 2 * s - ONE : s;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back('{cur_exp, cyc});
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", int'($signed(bus.out_data)), e.y);
          if (chk_lat) chk("latency", cyc - e.c, 3);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", int'(bus.in_ready), 0);
        if (prev_stall) chk("stall_hold", int'(bus.out_data), int'(prev_data));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end else prev_stall = 1'b0;
  end

  task automatic send(int x, bit md, int exp);
    bus.in_data = WL'(x);
    bus.in_mode = md;
    bus.in_valid = 1'b1;
    cur_exp = exp;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    chk("drain", int'(exp_q.size()), 0);
  endtask

  task automatic send_rand();
    int bl[15] = '{20480, 20479, 9728, 9727, 4096, 4095, 0, -1, -4096, -9728, -20480, -32768, 32767, 10240, -10240};
    int x;
    bit md;
    md = 1'($urandom_range(0, 1));
    x = ($urandom_range(0, 3) == 0) ? bl[$urandom_range(0, 14)] : int'($signed(16'($urandom)));
    send(x, md, model(x, md));
  endtask

  initial begin
    int dx[13] = '{0, 4096, -4096, 24576, -32768, 20480, 9728, 0, 2048, -2048, 16384, 6, 6};
    bit dm[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int de[13] = '{2048, 3072, 1024, 4096, 0, 4096, 3760, 0, 2048, -2048, 4096, X6_EXP, X6_EXP};
    bit done;
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", int'(bus.out_data), 0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", int'(bus.in_ready), 1);

    chk_lat = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(dx[i], dm[i], de[i]);
      if (i % 3 == 2) idle(2);
    end
    drain();
    chk_lat = 1'b0;

    fork
      for (int i = 0; i < 6; i++) send_rand();
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1 bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    bus.out_ready = 1'b1;
    drain();

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1000 * i, 1'(i), model(1000 * i, 1'(i)));
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    chk("post_rst_no_stale", int'(bus.out_valid), 0);
    chk_lat = 1'b1;
    send(4096, 1'b0, 3072);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
